// File: rtl/accel_data_router_if.sv
// Router bus bundle: shared-RAM control strobes plus the per-channel accelerator FIFO handshake.
// The tri-state RAM data bus stays a plain inout port on the router itself.
interface accel_data_router_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 10
);
  localparam int CH_BITS = $clog2(NUM_CH);

  logic [ADDR_WIDTH-1:0]        ram_addr;
  logic                         ram_read_enable;
  logic                         ram_write_enable;
  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            to_full;
  logic [NUM_CH-1:0]            from_empty;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_in;
  logic [NUM_CH-1:0]            ch_put_req;
  logic [NUM_CH-1:0]            ch_get_req;
  logic [DATA_WIDTH-1:0]        ch_data_out;
  logic                         busy;
  logic [CH_BITS-1:0]           cur_ch;

  modport master (
    output ram_addr, ram_read_enable, ram_write_enable,
    output ch_put_req, ch_get_req, ch_data_out, busy, cur_ch,
    input  ch_enable, to_full, from_empty, ch_data_in
  );

  modport slave (
    input  ram_addr, ram_read_enable, ram_write_enable,
    input  ch_put_req, ch_get_req, ch_data_out, busy, cur_ch,
    output ch_enable, to_full, from_empty, ch_data_in
  );
endinterface

// File: rtl/accel_data_router.sv
// Round-robin data router between one shared single-port RAM and NUM_CH accelerator FIFO pairs.
// Each channel owns a RAM region addressed {channel, pointer}; bursts are bounded by BURST_LEN.
module accel_data_router #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  accel_data_router_if.master   bus
);
  localparam int CH_BITS     = $clog2(NUM_CH);
  localparam int REGION_BITS = ADDR_WIDTH - CH_BITS;
  localparam int BEAT_BITS   = $clog2(BURST_LEN + 1);

  localparam logic [CH_BITS-1:0]     LAST_CH   = CH_BITS'(NUM_CH - 1);
  localparam logic [BEAT_BITS-1:0]   BURST_MAX = BEAT_BITS'(BURST_LEN);
  localparam logic [BEAT_BITS-1:0]   BEAT_ONE  = BEAT_BITS'(1);
  localparam logic [REGION_BITS-1:0] PTR_ONE   = REGION_BITS'(1);
  localparam logic [NUM_CH-1:0]      CH_ONE    = NUM_CH'(1);

  typedef enum logic [2:0] {
    ST_ARB   = 3'd0,
    ST_GET   = 3'd1,
    ST_LATCH = 3'd2,
    ST_WR    = 3'd3,
    ST_RD    = 3'd4,
    ST_CAP   = 3'd5,
    ST_PUT   = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [CH_BITS-1:0]     cur_ch_q, cur_ch_d;
  logic [CH_BITS-1:0]     last_grant_q, last_grant_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [REGION_BITS-1:0] rd_ptr_q [NUM_CH];
  logic [REGION_BITS-1:0] rd_ptr_d [NUM_CH];
  logic [REGION_BITS-1:0] wr_ptr_q [NUM_CH];
  logic [REGION_BITS-1:0] wr_ptr_d [NUM_CH];
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

  logic [NUM_CH-1:0]      out_req_s;
  logic [NUM_CH-1:0]      in_req_s;
  logic [NUM_CH-1:0]      req_s;
  logic                   grant_found_s;
  logic [CH_BITS-1:0]     grant_ch_s;
  logic [BEAT_BITS-1:0]   beat_inc_s;
  logic [DATA_WIDTH-1:0]  ch_word_s [NUM_CH];

  // Channel index `step` positions after `base`, wrapping at NUM_CH.
  function automatic logic [CH_BITS-1:0] rr_next(input logic [CH_BITS-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    return (sum >= NUM_CH) ? CH_BITS'(sum - NUM_CH) : CH_BITS'(sum);
  endfunction

  assign out_req_s  = bus.ch_enable & ~bus.from_empty;
  assign in_req_s   = bus.ch_enable & ~bus.to_full;
  assign req_s      = out_req_s | in_req_s;
  assign beat_inc_s = beat_q + BEAT_ONE;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    assign ch_word_s[g] = bus.ch_data_in[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first requester strictly after last_grant, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_ch_s    = {CH_BITS{1'b0}};
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!grant_found_s && req_s[rr_next(last_grant_q, k)]) begin
        grant_found_s = 1'b1;
        grant_ch_s    = rr_next(last_grant_q, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state, pointer and data-register update.
  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    wr_data_d    = wr_data_q;
    out_data_d   = out_data_q;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
    end

    case (state_q)
      ST_ARB: begin
        if (grant_found_s) begin
          cur_ch_d     = grant_ch_s;
          last_grant_d = grant_ch_s;
          beat_d       = {BEAT_BITS{1'b0}};
          // Outbound wins within a channel so accelerator results drain first.
          state_d      = out_req_s[grant_ch_s] ? ST_GET : ST_RD;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_GET: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        wr_data_d = ch_word_s[cur_ch_q];
        state_d   = ST_WR;
      end
      ST_WR: begin
        wr_ptr_d[cur_ch_q] = wr_ptr_q[cur_ch_q] + PTR_ONE;
        beat_d             = beat_inc_s;
        state_d            = ((beat_inc_s < BURST_MAX) && out_req_s[cur_ch_q]) ? ST_GET : ST_ARB;
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        out_data_d = data_bus;
        state_d    = ST_PUT;
      end
      ST_PUT: begin
        rd_ptr_d[cur_ch_q] = rd_ptr_q[cur_ch_q] + PTR_ONE;
        beat_d             = beat_inc_s;
        // to_full is sampled here, before the next RD, never after a word is fetched.
        state_d            = ((beat_inc_s < BURST_MAX) && in_req_s[cur_ch_q]) ? ST_RD : ST_ARB;
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State and datapath registers; reset clears every pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ARB;
      cur_ch_q     <= {CH_BITS{1'b0}};
      last_grant_q <= LAST_CH;
      beat_q       <= {BEAT_BITS{1'b0}};
      wr_data_q    <= {DATA_WIDTH{1'b0}};
      out_data_q   <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr_q[i] <= {REGION_BITS{1'b0}};
        wr_ptr_q[i] <= {REGION_BITS{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      wr_data_q    <= wr_data_d;
      out_data_q   <= out_data_d;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
      end
    end
  end

  // Strobes decode straight from the state register, so reset drops them asynchronously.
  assign bus.ram_read_enable  = (state_q == ST_RD);
  assign bus.ram_write_enable = (state_q == ST_WR);
  assign bus.ch_get_req       = (state_q == ST_GET) ? (CH_ONE << cur_ch_q) : {NUM_CH{1'b0}};
  assign bus.ch_put_req       = (state_q == ST_PUT) ? (CH_ONE << cur_ch_q) : {NUM_CH{1'b0}};
  assign bus.ram_addr         = (state_q == ST_RD) ? {cur_ch_q, rd_ptr_q[cur_ch_q]} :
                                (state_q == ST_WR) ? {cur_ch_q, wr_ptr_q[cur_ch_q]} :
                                {ADDR_WIDTH{1'b0}};
  assign bus.ch_data_out      = out_data_q;
  assign bus.busy             = (state_q != ST_ARB);
  assign bus.cur_ch           = cur_ch_q;
  assign data_bus             = (state_q == ST_WR) ? wr_data_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_accel_data_router.sv
// Directed bench for accel_data_router: RAM and FIFO models, grant vector table,
// and hand-written burst / full / reset sequences.
module tb_accel_data_router;
  localparam int DW  = 32;
  localparam int NCH = 3;
  localparam int AW  = 10;
  localparam int BL  = 4;

  logic clk = 1'b0;
  logic reset;
  wire [DW-1:0] data_bus;

  accel_data_router_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_WIDTH(AW)) bus_if ();

  accel_data_router #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_bus (data_bus),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  // RAM model: unwritten locations read back their own address.
  logic [DW-1:0] mem [1024];
  bit            mem_wr [1024];
  logic [DW-1:0] ram_q = '0;
  logic          ram_drive = 1'b0;
  assign data_bus = ram_drive ? ram_q : {DW{1'bz}};

  int            wr_addr_log [$];
  logic [DW-1:0] wr_data_log [$];
  int            rd_addr_log [$];
  int            rd_cyc_log  [$];
  logic [DW-1:0] put_data_log [$];
  int            put_ch_log  [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.ram_write_enable) begin
      mem[bus_if.ram_addr]    <= data_bus;
      mem_wr[bus_if.ram_addr] <= 1'b1;
      wr_addr_log.push_back(int'(bus_if.ram_addr));
      wr_data_log.push_back(data_bus);
    end
    if (bus_if.ram_read_enable) begin
      ram_q     <= mem_wr[bus_if.ram_addr] ? mem[bus_if.ram_addr] : DW'(bus_if.ram_addr);
      ram_drive <= 1'b1;
      rd_addr_log.push_back(int'(bus_if.ram_addr));
      rd_cyc_log.push_back(cyc);
    end else begin
      ram_drive <= 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (bus_if.ch_put_req[i]) begin
        put_data_log.push_back(bus_if.ch_data_out);
        put_ch_log.push_back(i);
      end
    end
  end

  // Accelerator-to-router FIFO models; popped word appears the cycle after get.
  logic [DW-1:0]     ofifo [NCH][32];
  int                otail [NCH];
  int                ohead [NCH];
  logic [NCH-1:0]    empty_mask = 3'b111;
  logic [NCH*DW-1:0] ch_data_r = '0;

  always_comb begin
    bus_if.from_empty = 3'b111;
    for (int i = 0; i < NCH; i++) bus_if.from_empty[i] = (ohead[i] == otail[i]) & empty_mask[i];
  end
  assign bus_if.ch_data_in = ch_data_r;

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (bus_if.ch_get_req[i] && (ohead[i] != otail[i])) begin
        ch_data_r[i*DW +: DW] <= ofifo[i][ohead[i]];
        ohead[i]              <= ohead[i] + 1;
      end
    end
  end

  task automatic load(input int ch, input logic [DW-1:0] w);
    ofifo[ch][otail[ch]] = w;
    otail[ch] = otail[ch] + 1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit bus_idle(input logic [DW-1:0] v);
    return (v === {DW{1'bz}}) || (v === {DW{1'b0}});
  endfunction

  // At most one RAM strobe or FIFO request in any cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      int cnt;
      cnt = int'(bus_if.ram_read_enable) + int'(bus_if.ram_write_enable) +
            $countones(bus_if.ch_put_req) + $countones(bus_if.ch_get_req);
      nvec++;
      if (cnt > 1) begin
        nfail++;
        $display("FAIL exclusive: got %0d strobes expected at most 1", cnt);
      end
    end
  end

  task automatic clear_logs();
    wr_addr_log.delete(); wr_data_log.delete();
    rd_addr_log.delete(); rd_cyc_log.delete();
    put_data_log.delete(); put_ch_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus_if.ch_enable = 3'b000;
    bus_if.to_full   = 3'b000;
    empty_mask       = 3'b111;
    clear_logs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_wr(input int n, input int budget);
    int t = 0;
    while (wr_addr_log.size() < n && t < budget) begin @(negedge clk); t++; end
    check("wr_timeout", 64'(wr_addr_log.size() >= n), 64'd1);
  endtask

  task automatic wait_rd(input int n, input int budget);
    int t = 0;
    while (rd_addr_log.size() < n && t < budget) begin @(negedge clk); t++; end
    check("rd_timeout", 64'(rd_addr_log.size() >= n), 64'd1);
  endtask

  typedef struct {
    logic [2:0] en;
    logic [2:0] full;
    logic [2:0] mask;
    logic       busy;
    logic [1:0] ch;
    logic [2:0] get;
    logic       re;
    logic [9:0] addr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // First cycle after release from reset (last_grant = 2).
    vecs[0] = '{3'b111, 3'b000, 3'b111, 1'b1, 2'd0, 3'b000, 1'b1, 10'h000};
    vecs[1] = '{3'b110, 3'b000, 3'b111, 1'b1, 2'd1, 3'b000, 1'b1, 10'h100};
    vecs[2] = '{3'b100, 3'b000, 3'b111, 1'b1, 2'd2, 3'b000, 1'b1, 10'h200};
    vecs[3] = '{3'b111, 3'b000, 3'b110, 1'b1, 2'd0, 3'b001, 1'b0, 10'h000};
    vecs[4] = '{3'b110, 3'b000, 3'b011, 1'b1, 2'd1, 3'b000, 1'b1, 10'h100};
    vecs[5] = '{3'b111, 3'b111, 3'b111, 1'b0, 2'd0, 3'b000, 1'b0, 10'h000};
    vecs[6] = '{3'b111, 3'b001, 3'b111, 1'b1, 2'd1, 3'b000, 1'b1, 10'h100};
    vecs[7] = '{3'b000, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 10'h000};
    vecs[8] = '{3'b101, 3'b111, 3'b011, 1'b1, 2'd2, 3'b100, 1'b0, 10'h000};
    vecs[9] = '{3'b011, 3'b011, 3'b101, 1'b1, 2'd1, 3'b010, 1'b0, 10'h000};

    // Reset with random inputs: everything quiet.
    reset = 1'b0;
    bus_if.ch_enable = 3'($urandom);
    bus_if.to_full   = 3'($urandom);
    empty_mask       = 3'($urandom);
    repeat (3) @(negedge clk);
    check("rst_addr",  64'(bus_if.ram_addr), 64'd0);
    check("rst_re",    64'(bus_if.ram_read_enable), 64'd0);
    check("rst_we",    64'(bus_if.ram_write_enable), 64'd0);
    check("rst_put",   64'(bus_if.ch_put_req), 64'd0);
    check("rst_get",   64'(bus_if.ch_get_req), 64'd0);
    check("rst_dout",  64'(bus_if.ch_data_out), 64'd0);
    check("rst_busy",  64'(bus_if.busy), 64'd0);
    check("rst_curch", 64'(bus_if.cur_ch), 64'd0);
    check("rst_bus_z", 64'(bus_idle(data_bus)), 64'd1);
    bus_if.ch_enable = 3'b000;
    bus_if.to_full   = 3'b000;
    empty_mask       = 3'b111;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(bus_if.busy), 64'd0);

    // Inbound bursts on ch0: reads 0..7, data = address, one ARB cycle between bursts.
    clear_logs();
    bus_if.ch_enable = 3'b001;
    wait_rd(8, 80);
    bus_if.ch_enable = 3'b000;
    repeat (6) @(negedge clk);
    check("in_nputs", 64'(put_data_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check("in_rd_addr", 64'(rd_addr_log[k]), 64'(k));
      check("in_put_data", 64'(put_data_log[k]), 64'(k));
      check("in_put_ch", 64'(put_ch_log[k]), 64'd0);
      if (k > 0) check("in_rd_gap", 64'(rd_cyc_log[k] - rd_cyc_log[k-1]), (k == 4) ? 64'd4 : 64'd3);
    end

    // Outbound priority on ch1, burst cut short by empty FIFO, then inbound grant.
    load(1, 32'h0000_00A5);
    load(1, 32'h0000_005A);
    do_reset();
    bus_if.ch_enable = 3'b010;
    wait_rd(1, 40);
    bus_if.ch_enable = 3'b000;
    repeat (6) @(negedge clk);
    check("ob_nwr", 64'(wr_addr_log.size()), 64'd2);
    check("ob_addr0", 64'(wr_addr_log[0]), 64'h100);
    check("ob_data0", 64'(wr_data_log[0]), 64'hA5);
    check("ob_addr1", 64'(wr_addr_log[1]), 64'h101);
    check("ob_data1", 64'(wr_data_log[1]), 64'h5A);
    check("ob_rd_addr", 64'(rd_addr_log[0]), 64'h100);

    // Round robin, outbound only: 0,1,2,0,1,2 with four writes each.
    do_reset();
    bus_if.to_full = 3'b111;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 8; k++) load(c, 32'hC0DE_0000 | DW'(c << 8) | DW'(k));
    bus_if.ch_enable = 3'b111;
    wait_wr(24, 400);
    for (int i = 0; i < 24; i++) begin
      int g, off;
      g   = (i / 4) % 3;
      off = (i / 12) * 4 + (i % 4);
      check("rr_addr", 64'(wr_addr_log[i]), 64'(g * 256 + off));
      check("rr_data", 64'(wr_data_log[i]), 64'(32'hC0DE_0000 | DW'(g << 8) | DW'(off)));
    end
    for (int c = 0; c < NCH; c++) load(c, 32'hBEEF_0000 | DW'(c));
    wait_wr(27, 100);
    for (int c = 0; c < NCH; c++) check("rr_ptr8", 64'(wr_addr_log[24 + c]), 64'(c * 256 + 8));
    bus_if.ch_enable = 3'b000;

    // ch2 inbound, FIFO reports full during the second put: no third read.
    do_reset();
    bus_if.ch_enable = 3'b100;
    begin
      int puts = 0;
      int t = 0;
      while (puts < 2 && t < 40) begin
        @(negedge clk);
        t++;
        if (bus_if.ch_put_req[2]) puts++;
      end
      bus_if.to_full = 3'b100;
      check("full_puts", 64'(puts), 64'd2);
    end
    repeat (12) @(negedge clk);
    check("full_nrd", 64'(rd_addr_log.size()), 64'd2);
    check("full_rd0", 64'(rd_addr_log[0]), 64'h200);
    check("full_rd1", 64'(rd_addr_log[1]), 64'h201);
    bus_if.to_full = 3'b000;
    wait_rd(3, 20);
    bus_if.ch_enable = 3'b000;
    check("full_rd2", 64'(rd_addr_log[2]), 64'h202);
    repeat (6) @(negedge clk);

    // Reset asserted mid-WR: bus released and strobe dropped at once, pointers cleared.
    load(1, 32'hDEAD_0001);
    load(1, 32'hDEAD_0002);
    load(1, 32'hDEAD_0003);
    do_reset();
    bus_if.to_full   = 3'b111;
    bus_if.ch_enable = 3'b010;
    begin
      int nwr = 0;
      int t = 0;
      while (nwr < 2 && t < 40) begin
        @(negedge clk);
        t++;
        if (bus_if.ram_write_enable) nwr++;
      end
      check("mwr_seen", 64'(nwr), 64'd2);
    end
    check("mwr_addr", 64'(bus_if.ram_addr), 64'h101);
    reset = 1'b0;
    #1;
    check("mwr_we", 64'(bus_if.ram_write_enable), 64'd0);
    check("mwr_bus_z", 64'(bus_idle(data_bus)), 64'd1);
    check("mwr_busy", 64'(bus_if.busy), 64'd0);
    check("mwr_addr0", 64'(bus_if.ram_addr), 64'd0);
    clear_logs();
    @(negedge clk);
    reset = 1'b1;
    wait_wr(1, 30);
    bus_if.ch_enable = 3'b000;
    check("mwr_first_addr", 64'(wr_addr_log[0]), 64'h100);
    check("mwr_first_data", 64'(wr_data_log[0]), 64'hDEAD_0003);
    repeat (6) @(negedge clk);

    // Grant/direction vectors, each applied straight out of reset.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      reset = 1'b0;
      bus_if.ch_enable = vecs[v].en;
      bus_if.to_full   = vecs[v].full;
      empty_mask       = vecs[v].mask;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_busy", v), 64'(bus_if.busy), 64'(vecs[v].busy));
      check($sformatf("v%0d_ch", v), 64'(bus_if.cur_ch), 64'(vecs[v].ch));
      check($sformatf("v%0d_get", v), 64'(bus_if.ch_get_req), 64'(vecs[v].get));
      check($sformatf("v%0d_re", v), 64'(bus_if.ram_read_enable), 64'(vecs[v].re));
      check($sformatf("v%0d_addr", v), 64'(bus_if.ram_addr), 64'(vecs[v].addr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
